wrap_ref_luma_ctrl: RTL and testbench

WRAP_REF_LUMA_CTRL -- requirements
Module: wrap_ref_luma_ctrl

---
 rtl/wrap_ref_luma_ctrl_pkg.sv | 31 +++
 rtl/wrap_ref_luma_arb.sv | 34 +++
 rtl/wrap_ref_luma_ctrl.sv | 115 +++++++++++
 tb/tb_wrap_ref_luma_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrap_ref_luma_ctrl_pkg.sv
// Shared encoder constants plus the types and ring arithmetic used by the
// reference-luma window controller.
package enc_defines;
    localparam int PIXEL_WIDTH = 8;
    localparam int WIN_LINES   = 96;
    localparam int SHIFT_LINES = 16;
    localparam int STARVE_MAX  = 4;
endpackage

package wrap_ref_luma_ctrl_pkg;
    import enc_defines::*;

    localparam int LINE_W = 96 * PIXEL_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FULL
    } win_state_t;

    // Ring add modulo the window size; both operands are below 96 whenever
    // the result is actually used, so one conditional subtract is enough.
    function automatic logic [6:0] ring_add(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 8'(WIN_LINES)) begin
            sum = sum - 8'(WIN_LINES);
        end
        return 7'(sum);
    endfunction
endpackage

// File: rtl/wrap_ref_luma_arb.sv
// Single-port memory arbiter: reads win by default, but a write that has
// watched STARVE_MAX read grants in a row takes the next slot.
module wrap_ref_luma_arb
    import enc_defines::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rd_elig,
    input  logic wr_elig,
    output logic rd_gnt,
    output logic wr_gnt
);

    logic [2:0] starve_cnt;
    logic       force_wr;

    always_comb begin
        force_wr = wr_elig && (starve_cnt >= 3'(STARVE_MAX));
        wr_gnt   = wr_elig && (!rd_elig || force_wr);
        rd_gnt   = rd_elig && !wr_gnt;
    end

    // The count only grows while a write is actually waiting behind a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!wr_elig || wr_gnt) begin
            starve_cnt <= '0;
        end else if (rd_gnt) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/wrap_ref_luma_ctrl.sv
// Reference-luma line window kept as a 96-line ring in an external
// single-port memory; lines are loaded at the tail and released 16 at a time.
module wrap_ref_luma_ctrl
    import enc_defines::*;
    import wrap_ref_luma_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        shift_i,
    input  logic                        ld_valid_i,
    output logic                        ld_ready_o,
    input  logic [96*PIXEL_WIDTH-1:0]   ld_data_i,
    input  logic                        rd_req_i,
    input  logic [6:0]                  rd_line_i,
    output logic                        rd_ack_o,
    output logic                        rd_dv_o,
    output logic [96*PIXEL_WIDTH-1:0]   rd_data_o,
    output logic                        mem_cen_o,
    output logic                        mem_wen_o,
    output logic [6:0]                  mem_addr_o,
    output logic [96*PIXEL_WIDTH-1:0]   mem_wdata_o,
    input  logic [96*PIXEL_WIDTH-1:0]   mem_rdata_i,
    output logic [6:0]                  win_cnt_o,
    output logic                        win_full_o,
    output logic                        shift_err_o
);

    win_state_t state_q, state_d;
    logic [6:0] base_q, base_d;
    logic [6:0] cnt_q, cnt_d;
    logic       full_q;
    logic       rd_dv_q;
    logic       shift_err_q;

    logic       active;
    logic       rd_elig, wr_elig;
    logic       rd_gnt, wr_gnt;
    logic       shift_ok, shift_bad;
    logic [6:0] rd_addr, wr_addr;

    // start_i and rst suppress every grant in their cycle.
    always_comb begin
        active    = (state_q != ST_IDLE) && !start_i && !rst;
        rd_elig   = active && rd_req_i && (rd_line_i < cnt_q);
        wr_elig   = active && ld_valid_i && (cnt_q < 7'(WIN_LINES));
        shift_ok  = shift_i && !start_i && (cnt_q >= 7'(SHIFT_LINES));
        shift_bad = shift_i && !start_i && (cnt_q < 7'(SHIFT_LINES));
        rd_addr   = ring_add(base_q, rd_line_i);
        wr_addr   = ring_add(base_q, cnt_q);
    end

    wrap_ref_luma_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .rd_elig (rd_elig),
        .wr_elig (wr_elig),
        .rd_gnt  (rd_gnt),
        .wr_gnt  (wr_gnt)
    );

    // A shift and a write in the same cycle net out to cnt+1-16; addresses
    // above were already formed from the pre-shift base and count.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            state_d = ST_FILL;
            base_d  = '0;
            cnt_d   = '0;
        end else begin
            if (shift_ok) begin
                base_d = ring_add(base_q, 7'(SHIFT_LINES));
            end
            cnt_d = cnt_q + 7'(wr_gnt) - (shift_ok ? 7'(SHIFT_LINES) : 7'd0);
            if (state_q != ST_IDLE) begin
                state_d = (cnt_d == 7'(WIN_LINES)) ? ST_FULL : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            rd_dv_q     <= 1'b0;
            shift_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            full_q      <= (cnt_d == 7'(WIN_LINES));
            rd_dv_q     <= rd_gnt;
            shift_err_q <= shift_bad;
        end
    end

    always_comb begin
        ld_ready_o  = wr_gnt;
        rd_ack_o    = rd_gnt;
        mem_cen_o   = !(rd_gnt || wr_gnt);
        mem_wen_o   = !wr_gnt;
        mem_addr_o  = wr_gnt ? wr_addr : rd_addr;
        mem_wdata_o = ld_data_i;
        rd_dv_o     = rd_dv_q;
        rd_data_o   = mem_rdata_i;
        win_cnt_o   = cnt_q;
        win_full_o  = full_q;
        shift_err_o = shift_err_q;
    end

endmodule

// File: tb/tb_wrap_ref_luma_ctrl.sv
// Directed bench for wrap_ref_luma_ctrl: a queue-based window model checked
// every cycle, plus hand-computed expectations at the interesting points.
module tb_wrap_ref_luma_ctrl;
    import enc_defines::*;

    localparam int DW = 96 * PIXEL_WIDTH;

    logic          clk = 1'b0;
    logic          rst, start_i, shift_i, ld_valid_i, rd_req_i;
    logic [6:0]    rd_line_i;
    logic [DW-1:0] ld_data_i;
    logic          ld_ready_o, rd_ack_o, rd_dv_o;
    logic [DW-1:0] rd_data_o;
    logic          mem_cen_o, mem_wen_o;
    logic [6:0]    mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;
    logic [6:0]    win_cnt_o;
    logic          win_full_o, shift_err_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wrap_ref_luma_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .shift_i     (shift_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_data_i   (ld_data_i),
        .rd_req_i    (rd_req_i),
        .rd_line_i   (rd_line_i),
        .rd_ack_o    (rd_ack_o),
        .rd_dv_o     (rd_dv_o),
        .rd_data_o   (rd_data_o),
        .mem_cen_o   (mem_cen_o),
        .mem_wen_o   (mem_wen_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .win_cnt_o   (win_cnt_o),
        .win_full_o  (win_full_o),
        .shift_err_o (shift_err_o)
    );

    // Single-port synchronous line memory with one-cycle read latency.
    logic [DW-1:0] mem [0:127];
    always @(posedge clk) begin
        if (!mem_cen_o) begin
            if (!mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
            else            mem_rdata_i     <= mem[mem_addr_o];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Window model: a queue of line payloads, oldest first, plus the ring base.
    logic [DW-1:0] win [$];
    int            m_base = 0;
    int            m_run = 0;
    bit            m_started = 1'b0;
    bit            m_dv = 1'b0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_dv_data = '0;

    always @(negedge clk) begin
        bit            active, rd_el, wr_el, exp_rd, exp_wr;
        int            sz, exp_addr;
        logic [DW-1:0] nxt_data;
        sz     = win.size();
        active = m_started && !start_i && !rst;
        rd_el  = active && rd_req_i && (int'(rd_line_i) < sz);
        wr_el  = active && ld_valid_i && (sz < WIN_LINES);
        exp_wr = wr_el && (!rd_el || m_run >= STARVE_MAX);
        exp_rd = rd_el && !exp_wr;

        checkOutput("ld_ready", 64'(ld_ready_o), 64'(exp_wr));
        checkOutput("rd_ack", 64'(rd_ack_o), 64'(exp_rd));
        checkOutput("mem_cen", 64'(mem_cen_o), 64'(!(exp_rd || exp_wr)));
        checkOutput("win_cnt", 64'(win_cnt_o), 64'(sz));
        checkOutput("win_full", 64'(win_full_o), 64'(sz == WIN_LINES));
        checkOutput("shift_err", 64'(shift_err_o), 64'(m_err));
        checkOutput("rd_dv", 64'(rd_dv_o), 64'(m_dv));
        if (exp_rd || exp_wr) begin
            exp_addr = exp_wr ? (m_base + sz) % WIN_LINES : (m_base + int'(rd_line_i)) % WIN_LINES;
            checkOutput("mem_wen", 64'(mem_wen_o), 64'(!exp_wr));
            checkOutput("mem_addr", 64'(mem_addr_o), 64'(exp_addr));
        end
        if (exp_wr) checkOutput("mem_wdata", mem_wdata_o[63:0], ld_data_i[63:0]);
        if (m_dv) begin
            checkOutput("rd_data_lo", rd_data_o[63:0], m_dv_data[63:0]);
            checkOutput("rd_data_hi", rd_data_o[DW-1 -: 64], m_dv_data[DW-1 -: 64]);
        end

        nxt_data = exp_rd ? win[rd_line_i] : '0;
        if (rst) begin
            win.delete();
            m_base = 0; m_run = 0; m_started = 1'b0; m_err = 1'b0; m_dv = 1'b0;
        end else if (start_i) begin
            win.delete();
            m_base = 0; m_run = 0; m_started = 1'b1; m_err = 1'b0; m_dv = 1'b0;
        end else begin
            m_err = shift_i && (sz < SHIFT_LINES);
            if (exp_wr) win.push_back(ld_data_i);
            if (shift_i && sz >= SHIFT_LINES) begin
                repeat (SHIFT_LINES) void'(win.pop_front());
                m_base = (m_base + SHIFT_LINES) % WIN_LINES;
            end
            if (!wr_el || exp_wr) m_run = 0;
            else if (exp_rd)      m_run++;
            m_dv      = exp_rd;
            m_dv_data = nxt_data;
        end
    end

    task automatic applyStimulus(input logic st, input logic sh, input logic lv,
                                 input logic rr, input logic [6:0] rl, input logic [31:0] tag);
        start_i    = st;
        shift_i    = sh;
        ld_valid_i = lv;
        rd_req_i   = rr;
        rd_line_i  = rl;
        ld_data_i  = {24{tag}};
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; shift_i = 1'b0; ld_valid_i = 1'b0;
        rd_req_i = 1'b0; rd_line_i = '0; ld_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: offered traffic is ignored.
        applyStimulus(0, 0, 1, 1, 0, 32'hC000_0000);
        checkOutput("idle_cnt", 64'(win_cnt_o), 64'd0);
        checkOutput("idle_full", 64'(win_full_o), 64'd0);
        checkOutput("idle_ready", 64'(ld_ready_o), 64'd0);
        checkOutput("idle_ack", 64'(rd_ack_o), 64'd0);
        checkOutput("idle_cen", 64'(mem_cen_o), 64'd1);
        checkOutput("idle_wen", 64'(mem_wen_o), 64'd1);
        checkOutput("idle_dv", 64'(rd_dv_o), 64'd0);
        checkOutput("idle_err", 64'(shift_err_o), 64'd0);
        step();

        // Fill 96 lines back to back, then a 97th is refused.
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        step();
        for (int i = 0; i < 96; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'hA000_0000 + 32'(i));
            checkOutput("fill_ready", 64'(ld_ready_o), 64'd1);
            checkOutput("fill_addr", 64'(mem_addr_o), 64'(i));
            step();
        end
        applyStimulus(0, 0, 1, 0, 0, 32'hDEAD_BEEF);
        checkOutput("full_ready", 64'(ld_ready_o), 64'd0);
        checkOutput("full_flag", 64'(win_full_o), 64'd1);
        checkOutput("full_cnt", 64'(win_cnt_o), 64'd96);
        step();

        // Release 16 and refill: writes land at physical 0..15.
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'hB000_0000 + 32'(i));
            checkOutput("wrap_addr", 64'(mem_addr_o), 64'(i));
            checkOutput("wrap_cnt", 64'(win_cnt_o), 64'(80 + i));
            step();
        end
        applyStimulus(0, 0, 0, 1, 7'd0, 32'h0);
        checkOutput("wrap_rd0_ack", 64'(rd_ack_o), 64'd1);
        checkOutput("wrap_rd0_addr", 64'(mem_addr_o), 64'd16);
        step();
        applyStimulus(0, 0, 0, 1, 7'd95, 32'h0);
        checkOutput("wrap_rd95_addr", 64'(mem_addr_o), 64'd15);
        checkOutput("wrap_rd0_dv", 64'(rd_dv_o), 64'd1);
        checkOutput("wrap_rd0_data", 64'(rd_data_o[31:0]), 64'h0000_0000_A000_0010);
        step();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("wrap_rd95_data", 64'(rd_data_o[31:0]), 64'h0000_0000_B000_000F);
        step();

        // Starvation: reads win four times, then the pending write.
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        step();
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 1, 1, 7'd3, 32'hC000_0100 + 32'(k));
            checkOutput("starve_ack", 64'(rd_ack_o), 64'((k % 5) != 4));
            checkOutput("starve_ready", 64'(ld_ready_o), 64'((k % 5) == 4));
            if (k > 0) checkOutput("starve_dv", 64'(rd_dv_o), 64'(((k - 1) % 5) != 4));
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("starve_cnt", 64'(win_cnt_o), 64'd83);
        step();

        // Read of a line not yet loaded waits for it.
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'hC000_0200 + 32'(i));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 7'd10, 32'h0);
            checkOutput("inv_ack", 64'(rd_ack_o), 64'd0);
            checkOutput("inv_cen", 64'(mem_cen_o), 64'd1);
            step();
        end
        applyStimulus(0, 0, 1, 1, 7'd10, 32'hC000_020A);
        checkOutput("inv_wr_ack", 64'(rd_ack_o), 64'd0);
        checkOutput("inv_wr_ready", 64'(ld_ready_o), 64'd1);
        step();
        applyStimulus(0, 0, 0, 1, 7'd10, 32'h0);
        checkOutput("inv_late_ack", 64'(rd_ack_o), 64'd1);
        checkOutput("inv_late_addr", 64'(mem_addr_o), 64'd10);
        step();

        // Shift with only 15 lines is refused with an error pulse.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'hC000_0300 + 32'(i));
            step();
        end
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        checkOutput("err_pre", 64'(shift_err_o), 64'd0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("err_pulse", 64'(shift_err_o), 64'd1);
        checkOutput("err_cnt", 64'(win_cnt_o), 64'd15);
        step();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("err_clear", 64'(shift_err_o), 64'd0);
        checkOutput("err_cnt_hold", 64'(win_cnt_o), 64'd15);
        step();

        // Shift at 40 together with a write leaves 25.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'hC000_0400 + 32'(i));
            step();
        end
        applyStimulus(0, 1, 1, 0, 0, 32'hC000_0500);
        checkOutput("shwr_ready", 64'(ld_ready_o), 64'd1);
        checkOutput("shwr_addr", 64'(mem_addr_o), 64'd40);
        step();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("shwr_cnt", 64'(win_cnt_o), 64'd25);
        checkOutput("shwr_err", 64'(shift_err_o), 64'd0);
        step();

        // start_i over a pending read: no ack, earlier data still delivered.
        applyStimulus(0, 0, 0, 1, 7'd0, 32'h0);
        checkOutput("st_pre_ack", 64'(rd_ack_o), 64'd1);
        step();
        applyStimulus(1, 0, 0, 1, 7'd0, 32'h0);
        checkOutput("st_ack", 64'(rd_ack_o), 64'd0);
        checkOutput("st_dv", 64'(rd_dv_o), 64'd1);
        checkOutput("st_cen", 64'(mem_cen_o), 64'd1);
        step();
        applyStimulus(0, 0, 0, 1, 7'd0, 32'h0);
        checkOutput("st_cnt", 64'(win_cnt_o), 64'd0);
        checkOutput("st_post_ack", 64'(rd_ack_o), 64'd0);
        checkOutput("st_post_dv", 64'(rd_dv_o), 64'd0);
        step();

        // Reset in the middle of a fill drops back to idle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'hC000_0600 + 32'(i));
            step();
        end
        rst = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 32'hC000_0605);
        checkOutput("rst_ready", 64'(ld_ready_o), 64'd0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 1, 0, 0, 32'hC000_0606);
        checkOutput("rst_idle_ready", 64'(ld_ready_o), 64'd0);
        checkOutput("rst_idle_cen", 64'(mem_cen_o), 64'd1);
        checkOutput("rst_idle_wen", 64'(mem_wen_o), 64'd1);
        checkOutput("rst_idle_cnt", 64'(win_cnt_o), 64'd0);
        checkOutput("rst_idle_full", 64'(win_full_o), 64'd0);
        checkOutput("rst_idle_dv", 64'(rd_dv_o), 64'd0);
        checkOutput("rst_idle_err", 64'(shift_err_o), 64'd0);
        step();

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 1, 0, 0, 32'hC000_0700);
        checkOutput("rst_start_ready", 64'(ld_ready_o), 64'd0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
